// File: rtl/uart_echo_tester_pkg.sv
// Shared definitions for the UART echo tester: FSM state encoding, frame
// geometry, default bit period, and a helper that picks one bit of an 8N1 frame.
package uart_echo_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ECHO,
    ST_CHECK,
    ST_FINISH
  } state_t;

  localparam int unsigned FRAME_BITS  = 10;
  localparam int unsigned DEF_MAX_CNT = 5208;
  localparam int unsigned BIT_IDX_W   = 4;

  // Bit idx of the frame {stop, data[7:0], start}; out-of-frame positions idle high
  function automatic logic frame_bit(input logic [7:0]           data,
                                     input logic [BIT_IDX_W-1:0] idx);
    logic [FRAME_BITS-1:0] fr;
    fr = {1'b1, data, 1'b0};
    if (idx >= BIT_IDX_W'(FRAME_BITS)) begin
      return 1'b1;
    end
    return fr[idx];
  endfunction

endpackage

// File: rtl/echo_rx_deser.sv
// 8N1 UART receiver for the echo path.
// Ports:
//   clk, rstn  - clock, synchronous active-low reset
//   rx         - asynchronous serial input
//   en         - receiver armed; when low any frame in progress is dropped
//   rx_byte    - last received data byte (held)
//   valid      - one-cycle pulse when rx_byte/frame_err are updated
//   frame_err  - stop bit of the last frame was sampled low (held)
module echo_rx_deser
  import uart_echo_tester_pkg::*;
#(
  parameter int unsigned MAX_CNT = DEF_MAX_CNT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  input  logic       en,
  output logic [7:0] rx_byte,
  output logic       valid,
  output logic       frame_err
);

  localparam int unsigned CNT_W = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0]     HALF     = CNT_W'(MAX_CNT / 2);
  localparam logic [CNT_W-1:0]     LAST     = CNT_W'(MAX_CNT - 1);
  localparam logic [BIT_IDX_W-1:0] STOP_IDX = BIT_IDX_W'(FRAME_BITS - 1);

  logic                 sync1;
  logic                 sync2;
  logic                 prev;
  logic                 active;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic [7:0]           shreg;

  // Synchronizer, start-edge detect, mid-bit sampling and shift register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      prev      <= 1'b1;
      active    <= 1'b0;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_byte   <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      prev  <= sync2;
      valid <= 1'b0;
      if (!en) begin
        active  <= 1'b0;
        cnt     <= '0;
        bit_idx <= '0;
      end else if (!active) begin
        if (prev && !sync2) begin
          active  <= 1'b1;
          cnt     <= '0;
          bit_idx <= '0;
        end
      end else begin
        if (cnt == LAST) begin
          cnt     <= '0;
          bit_idx <= bit_idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        if (cnt == HALF) begin
          if (bit_idx == '0) begin
            // Start bit gone high again by mid-bit: treat as a glitch
            if (sync2) begin
              active <= 1'b0;
            end
          end else if (bit_idx == STOP_IDX) begin
            // Return to idle at mid stop bit so a back-to-back frame is not missed
            active    <= 1'b0;
            valid     <= 1'b1;
            rx_byte   <= shreg;
            frame_err <= ~sync2;
          end else begin
            shreg <= {sync2, shreg[7:1]};
          end
        end
      end
    end
  end

endmodule

// File: rtl/uart_echo_tester.sv
// Sends NUM_BYTES incrementing pattern bytes over a UART and checks that each
// one comes back unchanged from an external echo device.
// Ports:
//   clk, rstn - clock, synchronous active-low reset
//   start     - begins a run when idle (level, ignored while busy)
//   rx        - serial input from the echo device
//   tx        - serial output to the echo device
//   busy      - run in progress
//   done      - one-cycle pulse at run completion
//   pass      - run finished with zero errors (held until next start)
//   err_cnt   - saturating count of mismatch/framing/timeout/overrun errors
//   timeout   - at least one byte timed out in this run
module uart_echo_tester
  import uart_echo_tester_pkg::*;
#(
  parameter int unsigned MAX_CNT   = DEF_MAX_CNT,
  parameter int unsigned NUM_BYTES = 16,
  parameter logic [7:0]  SEED      = 8'hA5,
  parameter int unsigned TO_BITS   = 20
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       rx,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic       timeout
);

  localparam int unsigned CNT_W     = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int unsigned TO_CYCLES = TO_BITS * MAX_CNT;
  localparam int unsigned TO_W      = $clog2(TO_CYCLES + 1);
  localparam logic [CNT_W-1:0]     BIT_LAST = CNT_W'(MAX_CNT - 1);
  localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(TO_CYCLES - 1);
  localparam logic [7:0]           LAST_IDX = 8'(NUM_BYTES - 1);
  localparam logic [BIT_IDX_W-1:0] STOP_IDX = BIT_IDX_W'(FRAME_BITS - 1);

  state_t               state;
  logic [CNT_W-1:0]     tx_cnt;
  logic [BIT_IDX_W-1:0] tx_bit;
  logic [7:0]           idx;
  logic [TO_W-1:0]      wait_cnt;
  logic                 to_flag;
  logic                 held_valid;
  logic                 held_ferr;
  logic [7:0]           held_data;

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr;

  logic       rx_en_c;
  logic       rx_new_c;
  logic [7:0] pattern_c;
  logic       overrun_c;
  logic       check_err_c;
  logic [1:0] err_inc_c;
  logic [8:0] err_sum_c;
  logic [7:0] err_next_c;

  // Receiver is live from the first SEND of a run until FINISH
  assign rx_en_c  = (state != ST_IDLE) && (state != ST_FINISH);
  assign rx_new_c = rx_valid && rx_en_c;

  assign pattern_c = SEED + idx;

  // A new byte landing on an unconsumed one is an overrun, unless CHECK frees the slot now
  assign overrun_c   = rx_new_c && held_valid && (state != ST_CHECK);
  assign check_err_c = (state == ST_CHECK) &&
                       (to_flag || !held_valid || held_ferr || (held_data != pattern_c));

  // Both error sources can fire in one cycle; saturate the combined increment
  assign err_inc_c  = {1'b0, overrun_c} + {1'b0, check_err_c};
  assign err_sum_c  = {1'b0, err_cnt} + {7'b0, err_inc_c};
  assign err_next_c = err_sum_c[8] ? 8'hFF : err_sum_c[7:0];

  echo_rx_deser #(
    .MAX_CNT(MAX_CNT)
  ) u_rx (
    .clk      (clk),
    .rstn     (rstn),
    .rx       (rx),
    .en       (rx_en_c),
    .rx_byte  (rx_byte),
    .valid    (rx_valid),
    .frame_err(rx_ferr)
  );

  // Run sequencer, serializer and result bookkeeping
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      timeout    <= 1'b0;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      idx        <= '0;
      wait_cnt   <= '0;
      to_flag    <= 1'b0;
      held_valid <= 1'b0;
      held_ferr  <= 1'b0;
      held_data  <= '0;
    end else begin
      done    <= 1'b0;
      err_cnt <= err_next_c;
      if (rx_new_c) begin
        held_valid <= 1'b1;
        held_data  <= rx_byte;
        held_ferr  <= rx_ferr;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_SEND;
            busy       <= 1'b1;
            pass       <= 1'b0;
            err_cnt    <= '0;
            timeout    <= 1'b0;
            idx        <= '0;
            to_flag    <= 1'b0;
            held_valid <= 1'b0;
            tx         <= 1'b0;
            tx_cnt     <= '0;
            tx_bit     <= '0;
          end
        end
        ST_SEND: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == STOP_IDX) begin
              state    <= ST_WAIT_ECHO;
              wait_cnt <= '0;
              tx       <= 1'b1;
            end else begin
              tx_bit <= tx_bit + 1'b1;
              tx     <= frame_bit(pattern_c, tx_bit + 1'b1);
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        ST_WAIT_ECHO: begin
          if (held_valid || rx_new_c) begin
            state <= ST_CHECK;
          end else if (wait_cnt == TO_LAST) begin
            state   <= ST_CHECK;
            to_flag <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          to_flag <= 1'b0;
          if (to_flag) begin
            timeout <= 1'b1;
          end
          // A byte arriving in this very cycle takes the slot for the next index
          if (!rx_new_c) begin
            held_valid <= 1'b0;
          end
          if (idx == LAST_IDX) begin
            state <= ST_FINISH;
            done  <= 1'b1;
            pass  <= (err_next_c == 8'd0);
          end else begin
            idx    <= idx + 1'b1;
            state  <= ST_SEND;
            tx     <= 1'b0;
            tx_cnt <= '0;
            tx_bit <= '0;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_tester.sv
// Directed bench for uart_echo_tester with a UART echo model on the rx line.
module tb_uart_echo_tester;

  localparam int unsigned MAX_CNT   = 16;
  localparam int unsigned NUM_BYTES = 16;
  localparam logic [7:0]  SEED      = 8'hA5;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b0;
  logic       start = 1'b0;
  logic       rx;
  logic       tx;
  logic       busy;
  logic       done;
  logic       pass;
  logic       timeout;
  logic [7:0] err_cnt;

  // mode 0: loopback, 1: echo model, 2: rx held high
  int   mode         = 0;
  int   xor_idx      = -1;
  int   ferr_idx     = -1;
  int   glitch_idx   = -1;
  bit   glitch_done  = 1'b0;
  logic echo_line    = 1'b1;
  logic glitch_line  = 1'b1;

  int n_checks     = 0;
  int n_fail       = 0;
  int done_cnt     = 0;
  int tx_start_cnt = 0;

  logic [7:0] tx_log [$];
  logic [9:0] echo_q [$];

  always #5 clk = ~clk;

  assign rx = (mode == 0) ? tx : ((mode == 2) ? 1'b1 : (echo_line & glitch_line));

  uart_echo_tester #(
    .MAX_CNT  (MAX_CNT),
    .NUM_BYTES(NUM_BYTES),
    .SEED     (SEED),
    .TO_BITS  (20)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .rx     (rx),
    .tx     (tx),
    .busy   (busy),
    .done   (done),
    .pass   (pass),
    .err_cnt(err_cnt),
    .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  // Decode every frame on tx; in echo mode queue a (possibly corrupted) reply
  initial begin : tx_monitor
    logic [7:0] b;
    logic [7:0] eb;
    logic       es;
    int         idx;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        tx_start_cnt++;
        idx = tx_start_cnt - 1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (MAX_CNT) @(negedge clk);
          b[i] = tx;
        end
        repeat (MAX_CNT) @(negedge clk);
        tx_log.push_back(b);
        if (mode == 1) begin
          eb = b;
          if (idx == xor_idx) eb = eb ^ 8'h01;
          es = (idx == ferr_idx) ? 1'b0 : 1'b1;
          echo_q.push_back({es, eb, 1'b0});
        end
      end
    end
  end

  initial begin : echo_sender
    logic [9:0] fr;
    forever begin
      @(negedge clk);
      if (echo_q.size() != 0) begin
        fr = echo_q.pop_front();
        for (int i = 0; i < 10; i++) begin
          echo_line = fr[i];
          repeat (MAX_CNT) @(negedge clk);
        end
        echo_line = 1'b1;
      end
    end
  end

  // Short low pulse on an idle rx line partway through a chosen tx frame
  initial begin : glitch_gen
    forever begin
      @(negedge clk);
      if (glitch_idx >= 0 && !glitch_done && tx_start_cnt == glitch_idx + 1) begin
        repeat (40) @(negedge clk);
        glitch_line = 1'b0;
        repeat (3) @(negedge clk);
        glitch_line = 1'b1;
        glitch_done = 1'b1;
      end
    end
  end

  task automatic do_run(input string tag, input int poke_at, input logic [7:0] exp_err,
                        input logic exp_pass, input logic exp_to);
    int base;
    bit seen;
    seen = 1'b0;
    tx_log.delete();
    tx_start_cnt = 0;
    glitch_done  = 1'b0;
    base = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("%s busy_on", tag), 32'(busy), 32'd1);
    chk($sformatf("%s cleared", tag), 32'({timeout, pass, err_cnt}), 32'd0);
    for (int c = 0; c < 20000 && !seen; c++) begin
      if (poke_at > 0 && c == poke_at) start = 1'b1;
      if (poke_at > 0 && c == poke_at + 4) start = 1'b0;
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    chk($sformatf("%s done_seen", tag), 32'(seen), 32'd1);
    chk($sformatf("%s err_cnt", tag), 32'(err_cnt), 32'(exp_err));
    chk($sformatf("%s pass", tag), 32'(pass), 32'(exp_pass));
    chk($sformatf("%s timeout", tag), 32'(timeout), 32'(exp_to));
    chk($sformatf("%s busy_at_done", tag), 32'(busy), 32'd1);
    @(negedge clk);
    chk($sformatf("%s done_pulse", tag), 32'(done), 32'd0);
    chk($sformatf("%s busy_off", tag), 32'(busy), 32'd0);
    chk($sformatf("%s pass_held", tag), 32'(pass), 32'(exp_pass));
    repeat (200) @(negedge clk);
    chk($sformatf("%s runs", tag), 32'(done_cnt - base), 32'd1);
    chk($sformatf("%s idle", tag), 32'(busy), 32'd0);
    chk($sformatf("%s nbytes", tag), 32'(tx_log.size()), 32'(NUM_BYTES));
    for (int k = 0; k < tx_log.size(); k++) begin
      chk($sformatf("%s tx_byte%0d", tag, k), 32'(tx_log[k]), 32'(SEED + 8'(k)));
    end
  endtask

  initial begin
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst tx", 32'(tx), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst pass", 32'(pass), 32'd0);
    chk("rst err_cnt", 32'(err_cnt), 32'd0);
    chk("rst timeout", 32'(timeout), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    mode = 0;
    do_run("loopback", 0, 8'd0, 1'b1, 1'b0);

    mode = 1; xor_idx = 3;
    do_run("xor3", 0, 8'd1, 1'b0, 1'b0);

    mode = 2; xor_idx = -1;
    do_run("rx_high", 0, 8'd16, 1'b0, 1'b1);

    mode = 1; ferr_idx = 5; glitch_idx = 7;
    do_run("ferr_glitch", 0, 8'd1, 1'b0, 1'b0);
    chk("glitch injected", 32'(glitch_done), 32'd1);

    mode = 0; ferr_idx = -1; glitch_idx = -1;
    do_run("start_busy", 1000, 8'd0, 1'b1, 1'b0);

    // Reset in the middle of data bit 4 of byte 2 (0xA7, bit 4 = 0)
    tx_log.delete();
    tx_start_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 2000 && tx_start_cnt < 3; c++) @(negedge clk);
    chk("rst_mid byte2 seen", 32'(tx_start_cnt), 32'd3);
    repeat (83) @(negedge clk);
    chk("rst_mid tx_before", 32'(tx), 32'd0);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid tx", 32'(tx), 32'd1);
    chk("rst_mid busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (200) @(negedge clk);
    chk("rst_mid still idle", 32'(busy), 32'd0);
    do_run("after_rst", 0, 8'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
